// File: rtl/add_sched_pkg.sv
// add_sched shared definitions: default sizing and the response record.
// Imported by the scheduler top and its response FIFO.
package add_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DW_DEF      = 9;
    localparam int IDW_DEF     = $clog2(NUM_REQ_DEF);
    localparam int RSP_DEPTH   = 2;
    localparam int CNT_W       = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [IDW_DEF-1:0] id;
        logic [DW_DEF:0]    data;
    } rsp_t;

endpackage

// File: rtl/add_sched_rsp_fifo.sv
// add_sched_rsp_fifo: in-order response buffer of RSP_DEPTH entries.
// Push and pop in the same cycle keep the count and the ordering.
module add_sched_rsp_fifo
    import add_sched_pkg::*;
#(
    parameter int W = $bits(rsp_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wr_data,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(RSP_DEPTH);

    logic [W-1:0]  mem [RSP_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/add_sched.sv
// add_sched: round-robin sharing of one registered adder between
// NUM_REQ requesters, with tagged in-order responses.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic                  add_in_valid,
    output logic [DW-1:0]         add_in0,
    output logic [DW-1:0]         add_in1,
    input  logic [DW:0]           add_data_out,
    input  logic                  add_out_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DW:0]           rsp_data,
    output logic                  err_unexp
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int OW  = CNT_W + 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW:0]    data;
    } rsp_w_t;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   inflight_id;
    logic             inflight_v;
    logic             found;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [OW-1:0]    outst;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    rsp_w_t           wr_rsp;
    rsp_w_t           rd_rsp;

    // First pass searches from rr_ptr upward, second pass wraps.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && IDW'(i) >= rr_ptr) begin
                grant = IDW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                grant = IDW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*DW +: DW];
                sel_b = req_b[i*DW +: DW];
            end
        end
    end

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign outst     = {1'b0, count} + OW'(inflight_v);
    // A same-cycle pop frees a credit, keeping one issue per cycle.
    assign issue     = (|req_valid) & (outst < OW'(2) + OW'(pop));

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign add_in_valid = issue;
    assign add_in0      = issue ? sel_a : '0;
    assign add_in1      = issue ? sel_b : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            inflight_v  <= 1'b0;
            inflight_id <= '0;
            err_unexp   <= 1'b0;
        end else begin
            if (issue) begin
                rr_ptr      <= (grant == IDW'(NUM_REQ - 1)) ?
                               '0 : grant + IDW'(1);
                inflight_v  <= 1'b1;
                inflight_id <= grant;
            end else if (add_out_valid) begin
                inflight_v  <= 1'b0;
            end
            if (add_out_valid && !inflight_v) begin
                err_unexp <= 1'b1;
            end
        end
    end

    assign push   = add_out_valid & inflight_v;
    assign wr_rsp = '{id: inflight_id, data: add_data_out};

    add_sched_rsp_fifo #(
        .W($bits(rsp_w_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_rsp),
        .rd_data (rd_rsp),
        .count   (count)
    );

    assign rsp_id   = rd_rsp.id;
    assign rsp_data = rd_rsp.data;

endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched: random stimulus, queue-based reference model and
// a decoupled response monitor around add_sched and a model adder.
module tb_add_sched;

    localparam int N  = 4;
    localparam int DW = 9;
    localparam int IW = $clog2(N);

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a;
    logic [N*DW-1:0]   req_b;
    logic              add_in_valid;
    logic [DW-1:0]     add_in0;
    logic [DW-1:0]     add_in1;
    logic [DW:0]       add_data_out;
    logic              add_out_valid;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW:0]       rsp_data;
    logic              err_unexp;
    logic              spur;

    add_sched #(.NUM_REQ(N), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .add_in_valid  (add_in_valid),
        .add_in0       (add_in0),
        .add_in1       (add_in1),
        .add_data_out  (add_data_out),
        .add_out_valid (add_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .err_unexp     (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared adder: one registered cycle, same reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            add_out_valid <= 1'b0;
            add_data_out  <= '0;
        end else begin
            add_out_valid <= add_in_valid | spur;
            add_data_out  <= {1'b0, add_in0} + {1'b0, add_in1};
        end
    end

    typedef struct {
        int id;
        int data;
        int cyc;
    } exp_t;

    exp_t     q[$];
    int       cyc;
    int       total;
    int       bad;
    int       ptr;
    int       n_iss;
    logic [N-1:0] acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit head_ready();
        if (q.size() == 0) return 1'b0;
        return q[0].cyc <= cyc - 2;
    endfunction

    // Issue side: expected grant/credit decision and expectation push.
    int           g;
    bit           popx;
    bit           exp_iss;
    int           ea;
    int           eb;
    logic [N-1:0] oh;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            ptr = 0;
            acc = '0;
        end else begin
            popx = rsp_ready && head_ready();
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
            end
            exp_iss = (g >= 0) && (q.size() - int'(popx) < 2);
            chk("add_in_valid", 32'(add_in_valid), 32'(exp_iss));
            acc = '0;
            if (exp_iss && add_in_valid) begin
                oh = '0;
                oh[g] = 1'b1;
                ea = int'(req_a[g*DW +: DW]);
                eb = int'(req_b[g*DW +: DW]);
                chk("req_ready", 32'(req_ready), 32'(oh));
                chk("add_in0", 32'(add_in0), 32'(ea));
                chk("add_in1", 32'(add_in1), 32'(eb));
                q.push_back('{g, ea + eb, cyc});
                ptr = (g + 1) % N;
                acc[g] = 1'b1;
                n_iss++;
            end else begin
                chk("req_ready_idle", 32'(req_ready), 32'd0);
            end
            if (dut.push && !dut.pop) begin
                chk("fifo_push_full", 32'(dut.u_fifo.count != 2), 32'd1);
            end
        end
    end

    // Response side: pops the scoreboard whenever a response leaves.
    bit expv;
    exp_t h;
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            expv = head_ready();
            chk("rsp_valid", 32'(rsp_valid), 32'(expv));
            if (expv && rsp_ready) begin
                h = q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(h.id));
                chk("rsp_data", 32'(rsp_data), 32'(h.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_valid[i]) begin
                req_a[i*DW +: DW] = DW'($urandom);
                req_b[i*DW +: DW] = DW'($urandom);
            end
        end
        req_valid = v;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #2;
    endtask

    int n0;

    initial begin
        cyc = 0; total = 0; bad = 0; n_iss = 0; ptr = 0;
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; spur = 1'b0;
        req_a = '0; req_b = '0; acc = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        at_neg();
        chk("idle_err", 32'(err_unexp), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        step();
        req_valid = 4'b0010;
        req_a[1*DW +: DW] = 9'd5;
        req_b[1*DW +: DW] = 9'd7;
        step();
        req_valid = '0;
        repeat (4) step();
        req_valid = 4'b1000;
        req_a[3*DW +: DW] = 9'd511;
        req_b[3*DW +: DW] = 9'd511;
        step();
        req_valid = '0;
        repeat (4) step();

        for (int c = 0; c < 20; c++) begin
            refresh(4'b1111);
            step();
        end
        req_valid = '0;
        repeat (4) step();

        n0 = n_iss;
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            refresh(4'b1111);
            step();
        end
        chk("bp_issues", 32'(n_iss - n0), 32'd2);
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            refresh(4'b1111);
            step();
        end
        req_valid = '0;
        repeat (4) step();

        req_valid = 4'b0100;
        step();
        req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            refresh(4'b1111);
            step();
        end

        for (int c = 0; c < 300; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            refresh(N'($urandom));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("drained", 32'(q.size()), 32'd0);

        at_neg();
        chk("pre_spur_err", 32'(err_unexp), 32'd0);
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (2) step();
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("err_sticky", 32'(err_unexp), 32'd1);
            chk("spur_count", 32'(dut.u_fifo.count), 32'd0);
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sched.md
Name: add_sched

Overview:
- Round-robin scheduler that shares one single-cycle adder (1-cycle registered latency, 9-bit operands, 10-bit sum) between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready, issues at most one pair per cycle to the adder, and tags each operation with the requester index.
- Returns each tagged result through a 2-entry response FIFO with valid/ready backpressure.
- Sits between the requester masters and the adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DW, 9, operand width; result width is DW+1
- IDW, $clog2(NUM_REQ), requester tag width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NUM_REQ*DW  operand B, same packing
- add_in_valid  out  1  to adder in_valid
- add_in0  out  DW  to adder data_in0
- add_in1  out  DW  to adder data_in1
- add_data_out  in  DW+1  from adder data_out
- add_out_valid  in  1  from adder out_valid
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accept
- rsp_id  out  IDW  requester index of the response
- rsp_data  out  DW+1  sum
- err_unexp  out  1  sticky: add_out_valid seen with nothing in flight

Behaviour:
- Reset: synchronous. Clears rr_ptr=0, inflight_v=0, FIFO count=0, err_unexp=0, which forces rsp_valid=0, req_ready=0 and add_in_valid=0. The adder shares rst_n. Reset mid-operation discards any in-flight op and all FIFO contents without producing a response.
- Arbitration:
  - Grant goes to the lowest index i >= rr_ptr with req_valid[i]; otherwise wrap to the lowest index below rr_ptr.
  - On issue, rr_ptr <= (grant+1) mod NUM_REQ. With no issue, rr_ptr holds.
- Credit rule:
  - pop = rsp_valid & rsp_ready.
  - issue = |req_valid & (count + inflight_v - pop < 2).
  - Outstanding work (in flight + buffered) never exceeds 2.
  - pop feeds combinationally into req_ready; this path is intentional and gives 1 op/cycle throughput under rsp_ready=1.
- Issue outputs (combinational):
  - req_ready[grant] = issue; all other bits 0.
  - add_in_valid = issue.
  - add_in0/add_in1 = granted req_a/req_b slices; 0 when not issuing.
- In-flight tracking:
  - On issue: inflight_v<=1, inflight_id<=grant.
  - Otherwise, if add_out_valid: inflight_v<=0.
  - The adder result arrives exactly 1 cycle after issue.
- Result capture:
  - On add_out_valid & inflight_v, push {inflight_id, add_data_out} into the FIFO.
  - On add_out_valid & !inflight_v, set err_unexp (sticky until reset) and push nothing.
- Response FIFO:
  - Depth 2, in-order. rsp_valid = (count != 0); rsp_id/rsp_data come from the head entry.
  - Simultaneous push and pop: count unchanged, data ordering preserved.
  - Push when full cannot occur under the credit rule; the bench asserts this.
- Arithmetic: no truncation; the full DW+1 sum is returned (511+511 = 1022).
- Ordering: responses leave in issue order. Starvation-free: every persistently-valid requester is granted within NUM_REQ issues.

Decomposition:
- Package add_sched_pkg: DW, NUM_REQ defaults; RSP_DEPTH=2; typedef rsp_t {id, data}.
- One natural sub-module: add_sched_rsp_fifo (2-entry synchronous FIFO of rsp_t, push/pop/count). Arbiter and credit logic stay in the top.

Test Plan:
- Reset then idle: no req_valid for 10 cycles -> req_ready=0, add_in_valid=0, rsp_valid=0, err_unexp=0.
- Single requester: req1 a=5 b=7, rsp_ready=1 -> req_ready[1] in issue cycle; rsp_valid 2 cycles later with id=1, data=12. Boundary case: a=511 b=511 -> data=1022.
- All four valid continuously, rsp_ready=1:
  - grants are 0,1,2,3,0,... one per cycle;
  - responses return in the same id order with correct sums.
- Backpressure: rsp_ready=0 with all four requesters valid:
  - exactly 2 issues occur, then req_ready stays 0;
  - raising rsp_ready drains in order and resumes 1 issue per cycle.
- Reset asserted the cycle after an issue:
  - no response is ever produced for that op;
  - rr_ptr returns to 0, so req0 is granted first afterwards.
- Spurious add_out_valid forced with nothing in flight -> err_unexp=1 and stays 1; FIFO count unchanged.
